// File: rtl/video_pkg.sv
// Shared video timing types and default 640x480 timing.
// Used by the scan controller and video_generator instances.
package video_pkg;

   localparam int unsigned PosW = 10;

   localparam int unsigned DefColTotal  = 800;
   localparam int unsigned DefColActive = 640;
   localparam int unsigned DefHFp       = 16;
   localparam int unsigned DefHSync     = 96;
   localparam int unsigned DefRowTotal  = 525;
   localparam int unsigned DefRowActive = 480;
   localparam int unsigned DefVFp       = 10;
   localparam int unsigned DefVSync     = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } scan_state_e;

   function automatic logic in_window(
      input logic [PosW-1:0] pos,
      input int unsigned     lo,
      input int unsigned     len
   );
      int unsigned p;
      p = {{(32-PosW){1'b0}}, pos};
      return (p >= lo) && (p < lo + len);
   endfunction

endpackage

// File: rtl/video_scan_ctrl_if.sv
// Control/status bundle between control logic and the scan controller.
// The slave side is the controller; the master side is control logic.
interface video_scan_ctrl_if;

   logic        start_i;
   logic        stop_i;
   logic        rdy_o;
   logic        hsync_o;
   logic        vsync_o;
   logic        sof_o;
   logic        busy_o;
   logic [15:0] frame_cnt_o;

   modport master (
      output start_i,
      output stop_i,
      input  rdy_o,
      input  hsync_o,
      input  vsync_o,
      input  sof_o,
      input  busy_o,
      input  frame_cnt_o
   );

   modport slave (
      input  start_i,
      input  stop_i,
      output rdy_o,
      output hsync_o,
      output vsync_o,
      output sof_o,
      output busy_o,
      output frame_cnt_o
   );

endinterface

// File: rtl/video_pos_counter.sv
// Row/column position counter advancing on a strobe.
// Wrap rules match the video generator's internal counters.
module video_pos_counter
   import video_pkg::*;
#(
   parameter int unsigned NumColTotal = DefColTotal,
   parameter int unsigned NumRowTotal = DefRowTotal
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            adv_i,
   output logic [PosW-1:0] row_o,
   output logic [PosW-1:0] col_o,
   output logic            frame_last_o
);

   localparam logic [PosW-1:0] ColLast = PosW'(NumColTotal - 1);
   localparam logic [PosW-1:0] RowLast = PosW'(NumRowTotal - 1);

   logic [PosW-1:0] row_d, row_q;
   logic [PosW-1:0] col_d, col_q;
   logic            col_last;
   logic            row_last;

   always_comb begin
      col_last = (col_q == ColLast);
      row_last = (row_q == RowLast);
      col_d    = col_q;
      row_d    = row_q;
      if (adv_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o        = row_q;
   assign col_o        = col_q;
   assign frame_last_o = col_last && row_last;

endmodule

// File: rtl/video_scan_ctrl.sv
// Frame-level scan sequencer: paces the generator strobe and
// produces syncs aligned with the generator's den/pix outputs.
module video_scan_ctrl
   import video_pkg::*;
#(
   parameter int unsigned NumColTotal   = DefColTotal,
   parameter int unsigned NumColActive  = DefColActive,
   parameter int unsigned HFrontPorch   = DefHFp,
   parameter int unsigned HSyncWidth    = DefHSync,
   parameter int unsigned NumRowTotal   = DefRowTotal,
   parameter int unsigned NumRowActive  = DefRowActive,
   parameter int unsigned VFrontPorch   = DefVFp,
   parameter int unsigned VSyncWidth    = DefVSync,
   parameter int unsigned ClkDiv        = 1,
   parameter bit          SyncActiveLow = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   video_scan_ctrl_if.slave  bus
);

   localparam logic [3:0] DivLast = 4'(ClkDiv - 1);
   localparam logic       SyncLow = SyncActiveLow;
   localparam int unsigned HsLo   = NumColActive + HFrontPorch;
   localparam int unsigned VsLo   = NumRowActive + VFrontPorch;

   scan_state_e     state_d, state_q;
   logic [3:0]      div_d, div_q;
   logic            hs_d, hs_q;
   logic            vs_d, vs_q;
   logic [15:0]     fcnt_d, fcnt_q;
   logic [PosW-1:0] row, col;
   logic            frame_last;
   logic            busy;
   logic            rdy;
   logic            frame_done;

   video_pos_counter #(
      .NumColTotal (NumColTotal),
      .NumRowTotal (NumRowTotal)
   ) u_pos (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .adv_i        (rdy),
      .row_o        (row),
      .col_o        (col),
      .frame_last_o (frame_last)
   );

   assign busy       = (state_q != ST_IDLE);
   assign rdy        = busy && (div_q == 4'd0);
   assign frame_done = rdy && frame_last;

   // A cancel (start without stop) in DRAIN keeps scanning even
   // when it lands on the last pixel, so no frame gap appears.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.stop_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.start_i && !bus.stop_i) state_d = ST_RUN;
            else if (frame_done)            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      div_d = div_q + 4'd1;
      if (!busy || div_q == DivLast) div_d = 4'd0;
   end

   always_comb begin
      hs_d   = hs_q;
      vs_d   = vs_q;
      fcnt_d = fcnt_q;
      if (rdy) begin
         hs_d = in_window(col, HsLo, HSyncWidth) ^ SyncLow;
         vs_d = in_window(row, VsLo, VSyncWidth) ^ SyncLow;
      end
      if (frame_done) fcnt_d = fcnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         div_q   <= 4'd0;
         hs_q    <= SyncLow;
         vs_q    <= SyncLow;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign bus.rdy_o       = rdy;
   assign bus.hsync_o     = hs_q;
   assign bus.vsync_o     = vs_q;
   assign bus.sof_o       = rdy && (row == '0) && (col == '0);
   assign bus.busy_o      = busy;
   assign bus.frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_video_scan_ctrl.sv
// Scoreboard bench for video_scan_ctrl on a small 10x5 timing.
// Stimulus queues expected strobes; a negedge monitor checks them.
module tb_video_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   nstrobe = 0;

   typedef struct {
      bit sof;
      bit hs;
      bit vs;
      int fc;
      bit chk_gap;
   } exp_t;

   exp_t exp_q[$];

   video_scan_ctrl_if vif ();

   video_scan_ctrl #(
      .NumColTotal   (10),
      .NumColActive  (6),
      .HFrontPorch   (1),
      .HSyncWidth    (2),
      .NumRowTotal   (5),
      .NumRowActive  (3),
      .VFrontPorch   (1),
      .VSyncWidth    (1),
      .ClkDiv        (4),
      .SyncActiveLow (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (vif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Hand-derived: hsync asserted (low) at cols 7..8, vsync at row 4.
   task automatic push_frame(input int fc, input bit first);
      exp_t it;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 10; c++) begin
            it.sof     = (r == 0 && c == 0);
            it.hs      = !(c == 7 || c == 8);
            it.vs      = !(r == 4);
            it.fc      = fc;
            it.chk_gap = !(first && r == 0 && c == 0);
            exp_q.push_back(it);
         end
      end
   endtask

   // Monitor: sync outputs seen at a strobe reflect the previous strobe.
   bit   hs_sh = 1'b1;
   bit   vs_sh = 1'b1;
   bit   have_last = 1'b0;
   int   last_cyc = 0;
   exp_t mit;

   always @(negedge clk) begin
      if (rst) begin
         hs_sh     = 1'b1;
         vs_sh     = 1'b1;
         have_last = 1'b0;
      end else if (vif.rdy_o) begin
         nstrobe++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
         end else begin
            mit = exp_q.pop_front();
            chk("sof", int'(vif.sof_o), int'(mit.sof));
            chk("hsync", int'(vif.hsync_o), int'(hs_sh));
            chk("vsync", int'(vif.vsync_o), int'(vs_sh));
            chk("frame_cnt", int'(vif.frame_cnt_o), mit.fc);
            chk("busy_on_strobe", int'(vif.busy_o), 1);
            if (mit.chk_gap && have_last)
               chk("strobe_gap", cyc - last_cyc, 4);
            hs_sh = mit.hs;
            vs_sh = mit.vs;
         end
         last_cyc  = cyc;
         have_last = 1'b1;
      end
   end

   task automatic pulse(input logic s, input logic p);
      @(negedge clk);
      vif.start_i = s;
      vif.stop_i  = p;
      @(negedge clk);
      vif.start_i = 1'b0;
      vif.stop_i  = 1'b0;
   endtask

   task automatic wait_strobes(input int target, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk);
         #1;
         if (nstrobe >= target) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got %0d strobes expected %0d", name, nstrobe, target);
      end
   endtask

   initial begin
      int b;
      vif.start_i = 1'b0;
      vif.stop_i  = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy", int'(vif.rdy_o), 0);
      chk("rst_busy", int'(vif.busy_o), 0);
      chk("rst_fc", int'(vif.frame_cnt_o), 0);
      chk("rst_hsync", int'(vif.hsync_o), 1);
      chk("rst_vsync", int'(vif.vsync_o), 1);
      chk("rst_sof", int'(vif.sof_o), 0);

      // Run two frames, stop requested at row 2 of the second.
      b = nstrobe;
      push_frame(0, 1'b1);
      push_frame(1, 1'b0);
      pulse(1'b1, 1'b0);
      chk("first_rdy", int'(vif.rdy_o), 1);
      chk("first_sof", int'(vif.sof_o), 1);
      wait_strobes(b + 75, "mid_frame");
      pulse(1'b0, 1'b1);
      chk("drain_busy", int'(vif.busy_o), 1);
      wait_strobes(b + 100, "drain_end");
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(vif.busy_o), 0);
      chk("idle_fc", int'(vif.frame_cnt_o), 2);
      chk("idle_hsync", int'(vif.hsync_o), 1);
      chk("idle_vsync_held", int'(vif.vsync_o), 0);
      repeat (12) @(negedge clk);
      chk("idle_rdy", int'(vif.rdy_o), 0);
      chk("idle_nstrobe", nstrobe, b + 100);

      // Stop then cancel in DRAIN; then start+stop on the last pixel.
      b = nstrobe;
      push_frame(2, 1'b1);
      push_frame(3, 1'b0);
      push_frame(4, 1'b0);
      pulse(1'b1, 1'b0);
      wait_strobes(b + 10, "cancel_point");
      pulse(1'b0, 1'b1);
      chk("drain2_busy", int'(vif.busy_o), 1);
      pulse(1'b1, 1'b0);
      wait_strobes(b + 99, "pre_last");
      repeat (3) @(negedge clk);
      pulse(1'b1, 1'b1);
      chk("after_last_busy", int'(vif.busy_o), 1);
      chk("after_last_fc", int'(vif.frame_cnt_o), 4);
      wait_strobes(b + 150, "drain_frame");
      repeat (2) @(negedge clk);
      chk("idle2_busy", int'(vif.busy_o), 0);
      chk("idle2_fc", int'(vif.frame_cnt_o), 5);

      // Reset mid-line, then restart and drain one frame.
      b = nstrobe;
      push_frame(5, 1'b1);
      pulse(1'b1, 1'b0);
      wait_strobes(b + 7, "pre_reset");
      rst = 1'b1;
      #1;
      chk("mrst_rdy", int'(vif.rdy_o), 0);
      chk("mrst_busy", int'(vif.busy_o), 0);
      chk("mrst_fc", int'(vif.frame_cnt_o), 0);
      chk("mrst_hsync", int'(vif.hsync_o), 1);
      chk("mrst_vsync", int'(vif.vsync_o), 1);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      b = nstrobe;
      push_frame(0, 1'b1);
      pulse(1'b1, 1'b0);
      chk("restart_sof", int'(vif.sof_o), 1);
      repeat (5) @(negedge clk);
      pulse(1'b0, 1'b1);
      wait_strobes(b + 50, "restart_frame");
      repeat (2) @(negedge clk);
      chk("final_busy", int'(vif.busy_o), 0);
      chk("final_fc", int'(vif.frame_cnt_o), 1);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish by 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
